// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 captures operands; S2 computes and holds the result and flags.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         alu_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_v,
  output logic               flag_n
);

  localparam int SHW = $clog2(WIDTH);
  localparam int W2  = 2 * WIDTH;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_MULS,
    OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLL, OP_SRL, OP_SRA, OP_ROL,
    OP_ROR, OP_SLT, OP_SLTU, OP_PASSA
  } alu_op_e;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  alu_op_e          op_q, op_d;
  logic             s1_valid_q, s1_valid_d;
  logic [W2-1:0]    out_q, out_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             n_q, n_d;
  logic             out_valid_q, out_valid_d;

  logic s1_load;
  logic s2_load;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [W2-1:0]    sa_ext;
  logic [W2-1:0]    sb_ext;
  logic [W2-1:0]    mul_u;
  logic [W2-1:0]    mul_s;
  logic [W2-1:0]    rol_w;
  logic [W2-1:0]    ror_w;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] lo;
  logic [W2-1:0]    res;
  logic             is_mul;
  logic             res_c;
  logic             res_v;
  logic             slt;
  logic             sltu;
  logic             msb_a;
  logic             msb_b;

  always_comb begin
    s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_load;
    s1_load  = in_valid && in_ready;
  end

  always_comb begin
    msb_a  = a_q[WIDTH-1];
    msb_b  = b_q[WIDTH-1];
    add_w  = {1'b0, a_q} + {1'b0, b_q};
    sub_w  = {1'b0, a_q} - {1'b0, b_q};
    sa_ext = {{WIDTH{msb_a}}, a_q};
    sb_ext = {{WIDTH{msb_b}}, b_q};
    mul_u  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    // Product of sign-extended operands, mod 2^W2, is the signed product.
    mul_s  = sa_ext * sb_ext;
    sh     = b_q[SHW-1:0];
    rol_w  = {a_q, a_q} << sh;
    ror_w  = {a_q, a_q} >> sh;
    slt    = $signed(a_q) < $signed(b_q);
    sltu   = a_q < b_q;
    lo     = '0;
    is_mul = 1'b0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        lo    = add_w[WIDTH-1:0];
        res_c = add_w[WIDTH];
        res_v = (msb_a == msb_b) && (add_w[WIDTH-1] != msb_a);
      end
      OP_SUB: begin
        lo    = sub_w[WIDTH-1:0];
        res_c = sub_w[WIDTH];
        res_v = (msb_a != msb_b) && (sub_w[WIDTH-1] != msb_a);
      end
      OP_MUL:   is_mul = 1'b1;
      OP_MULS:  is_mul = 1'b1;
      OP_AND:   lo = a_q & b_q;
      OP_OR:    lo = a_q | b_q;
      OP_XOR:   lo = a_q ^ b_q;
      OP_NOR:   lo = ~(a_q | b_q);
      OP_SLL:   lo = a_q << sh;
      OP_SRL:   lo = a_q >> sh;
      OP_SRA:   lo = $unsigned($signed(a_q) >>> sh);
      OP_ROL:   lo = rol_w[W2-1:WIDTH];
      OP_ROR:   lo = ror_w[WIDTH-1:0];
      OP_SLT:   lo = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU:  lo = {{(WIDTH-1){1'b0}}, sltu};
      OP_PASSA: lo = a_q;
    endcase
    if (op_q == OP_MULS) begin
      res = mul_s;
    end else if (is_mul) begin
      res = mul_u;
    end else begin
      res = {{WIDTH{1'b0}}, lo};
    end
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    s1_valid_d  = s1_valid_q;
    out_d       = out_q;
    z_d         = z_q;
    c_d         = c_q;
    v_d         = v_q;
    n_d         = n_q;
    out_valid_d = out_valid_q;
    if (s1_load) begin
      a_d  = a;
      b_d  = b;
      op_d = alu_op_e'(alu_sel);
    end
    if (s1_load) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
    if (s2_load) begin
      out_d       = res;
      z_d         = is_mul ? (res == '0) : (lo == '0);
      c_d         = res_c;
      v_d         = res_v;
      n_d         = is_mul ? res[W2-1] : lo[WIDTH-1];
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      s1_valid_q  <= 1'b0;
      out_q       <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      s1_valid_q  <= s1_valid_d;
      out_q       <= out_d;
      z_q         <= z_d;
      c_q         <= c_d;
      v_q         <= v_d;
      n_q         <= n_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign flag_n    = n_q;
  assign out_valid = out_valid_q;

endmodule
